trace_mem_ctrl: RTL and testbench

- Sequences and arbitrates the single-port trace memory between three requesters: Tracer stores (STORE), Tracer read requests (REQ/LOAD) and the host debug port.
- Owns the write/read pointers and the post-trigger delay counter.
- Generates TRG_DELAYED back to the Tracer and freezes the buffer once the delay expires.
- Sits between the Tracer and the BRAM wrapper, in the FPGA clock domain.

---
 rtl/trace_mem_ctrl_pkg.sv | 23 ++
 rtl/trace_mem_ctrl_arbiter.sv | 70 +++++++
 rtl/trace_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_trace_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_mem_ctrl_pkg.sv
// Shared types and defaults for the trace buffer memory controller.
// Sizes, address type, controller state and grant encodings.
package trace_mem_ctrl_pkg;

    localparam int TRB_WIDTH = 32;
    localparam int TRB_DEPTH = 1024;

    typedef logic [$clog2(TRB_DEPTH)-1:0] trb_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } mem_ctrl_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_STORE,
        GNT_READ,
        GNT_HOST
    } grant_t;

endpackage

// File: rtl/trace_mem_ctrl_arbiter.sv
// Pending-request flags and fixed-priority grant (store > read > host)
// for the single-port trace memory.
module trace_mem_arbiter
    import trace_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = TRB_WIDTH
) (
    input  logic              FPGA_CLK_I,
    input  logic              RST_I,
    input  logic              flush,
    input  logic              tracer_en,
    input  logic              read_en,
    input  logic              discard,
    input  logic              host_block,
    input  logic              STORE_I,
    input  logic              REQ_I,
    input  logic              HOST_REQ_I,
    input  logic [DATA_W-1:0] TR_DATA_I,
    output grant_t            grant,
    output logic [DATA_W-1:0] store_wdata
);

    logic              st_pend;
    logic              rd_pend;
    logic              err_ovr;
    logic [DATA_W-1:0] st_data;
    logic              st_req;
    logic              rd_req;

    // A fresh pulse is eligible in its own cycle; the flag only holds it over.
    assign st_req      = st_pend || STORE_I;
    assign rd_req      = rd_pend || REQ_I;
    assign store_wdata = st_pend ? st_data : TR_DATA_I;

    // NOTE: default first so every path assigns grant and no latch is inferred.
    always_comb begin
        grant = GNT_NONE;
        if (!RST_I) begin
            if (tracer_en && st_req)
                grant = GNT_STORE;
            else if (read_en && rd_req)
                grant = GNT_READ;
            else if (HOST_REQ_I && !host_block)
                grant = GNT_HOST;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            st_pend <= 1'b0;
            rd_pend <= 1'b0;
            err_ovr <= 1'b0;
            st_data <= '0;
        end else begin
            err_ovr <= err_ovr || (STORE_I && st_pend) || (REQ_I && rd_pend);
            if (flush || discard)
                st_pend <= 1'b0;
            else
                st_pend <= st_req && (grant != GNT_STORE);
            if (flush)
                rd_pend <= 1'b0;
            else
                rd_pend <= rd_req && (grant != GNT_READ);
            if (STORE_I && !st_pend)
                st_data <= TR_DATA_I;
        end
    end

endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace memory controller: pointers, post-trigger delay, run/freeze FSM
// and read-return registers around the store/read/host arbiter.
module trace_mem_ctrl
    import trace_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = TRB_WIDTH,
    parameter int DEPTH  = TRB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              FPGA_CLK_I,
    input  logic              RST_I,
    input  logic              EN_I,
    input  logic              MODE_I,
    input  logic [ADDR_W-1:0] TRIG_DELAY_I,
    input  logic              STORE_I,
    input  logic [DATA_W-1:0] TR_DATA_I,
    input  logic              REQ_I,
    output logic              LOAD_O,
    output logic [DATA_W-1:0] TR_DATA_O,
    input  logic              TRG_EVENT_I,
    output logic              TRG_DELAYED_O,
    output logic [ADDR_W-1:0] EVENT_ADDR_O,
    input  logic              HOST_REQ_I,
    input  logic              HOST_WE_I,
    input  logic [ADDR_W-1:0] HOST_ADDR_I,
    input  logic [DATA_W-1:0] HOST_DATA_I,
    output logic [DATA_W-1:0] HOST_DATA_O,
    output logic              HOST_ACK_O,
    output logic              MEM_EN_O,
    output logic              MEM_WE_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic [DATA_W-1:0] MEM_WDATA_O,
    input  logic [DATA_W-1:0] MEM_RDATA_I
);

    mem_ctrl_state_t   state;
    grant_t            grant;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] dly;
    logic              trig_seen;
    logic              host_rd_q;
    logic [DATA_W-1:0] tr_hold;
    logic [DATA_W-1:0] host_hold;
    logic [DATA_W-1:0] store_wdata;
    logic              flush;
    logic              tracer_en;
    logic              read_en;
    logic              trig_now;

    assign flush     = (state != ST_IDLE) && !EN_I;
    assign tracer_en = EN_I && (state == ST_RUN);
    assign read_en   = EN_I && (state != ST_IDLE);
    assign trig_now  = tracer_en && !MODE_I && TRG_EVENT_I && !trig_seen;

    trace_mem_arbiter #(.DATA_W(DATA_W)) u_arb (
        .FPGA_CLK_I  (FPGA_CLK_I),
        .RST_I       (RST_I),
        .flush       (flush),
        .tracer_en   (tracer_en),
        .read_en     (read_en),
        .discard     (state == ST_FROZEN),
        .host_block  (HOST_ACK_O),
        .STORE_I     (STORE_I),
        .REQ_I       (REQ_I),
        .HOST_REQ_I  (HOST_REQ_I),
        .TR_DATA_I   (TR_DATA_I),
        .grant       (grant),
        .store_wdata (store_wdata)
    );

    always_comb begin
        MEM_EN_O    = 1'b0;
        MEM_WE_O    = 1'b0;
        MEM_ADDR_O  = '0;
        MEM_WDATA_O = '0;
        case (grant)
            GNT_STORE: begin
                MEM_EN_O    = 1'b1;
                MEM_WE_O    = 1'b1;
                MEM_ADDR_O  = wr_ptr;
                MEM_WDATA_O = store_wdata;
            end
            // Trace mode reads the oldest word, which sits at the write pointer.
            GNT_READ: begin
                MEM_EN_O   = 1'b1;
                MEM_ADDR_O = MODE_I ? rd_ptr : wr_ptr;
            end
            GNT_HOST: begin
                MEM_EN_O    = 1'b1;
                MEM_WE_O    = HOST_WE_I;
                MEM_ADDR_O  = HOST_ADDR_I;
                MEM_WDATA_O = HOST_DATA_I;
            end
            default: ;
        endcase
    end

    // Read data is passed through in the load cycle, then held.
    assign TR_DATA_O   = LOAD_O    ? MEM_RDATA_I : tr_hold;
    assign HOST_DATA_O = host_rd_q ? MEM_RDATA_I : host_hold;

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            dly           <= '0;
            trig_seen     <= 1'b0;
            TRG_DELAYED_O <= 1'b0;
            EVENT_ADDR_O  <= '0;
            LOAD_O        <= 1'b0;
            HOST_ACK_O    <= 1'b0;
            host_rd_q     <= 1'b0;
            tr_hold       <= '0;
            host_hold     <= '0;
        end else begin
            LOAD_O     <= (grant == GNT_READ);
            HOST_ACK_O <= (grant == GNT_HOST);
            host_rd_q  <= (grant == GNT_HOST) && !HOST_WE_I;
            if (LOAD_O)
                tr_hold <= MEM_RDATA_I;
            if (host_rd_q)
                host_hold <= MEM_RDATA_I;

            if (flush) begin
                state         <= ST_IDLE;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                dly           <= '0;
                trig_seen     <= 1'b0;
                TRG_DELAYED_O <= 1'b0;
            end else begin
                if (state == ST_IDLE && EN_I)
                    state <= ST_RUN;
                if (grant == GNT_READ && MODE_I)
                    rd_ptr <= rd_ptr + 1'b1;
                if (grant == GNT_STORE) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (trig_seen && !MODE_I) begin
                        if (dly == '0) begin
                            TRG_DELAYED_O <= 1'b1;
                            state         <= ST_FROZEN;
                        end else begin
                            dly <= dly - 1'b1;
                        end
                    end
                end
                // A store in the trigger cycle is pre-trigger: mark the slot after it.
                if (trig_now) begin
                    trig_seen    <= 1'b1;
                    dly          <= TRIG_DELAY_I;
                    EVENT_ADDR_O <= (grant == GNT_STORE) ? wr_ptr + 1'b1 : wr_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed bench for trace_mem_ctrl with an 8-deep, 16-bit memory model
// that has a one-cycle read latency.
module tb_trace_mem_ctrl;
    import trace_mem_ctrl_pkg::*;

    logic        clk;
    logic        RST_I, EN_I, MODE_I, STORE_I, REQ_I, TRG_EVENT_I;
    logic        HOST_REQ_I, HOST_WE_I;
    logic [2:0]  TRIG_DELAY_I, HOST_ADDR_I;
    logic [15:0] TR_DATA_I, HOST_DATA_I;
    logic        LOAD_O, TRG_DELAYED_O, HOST_ACK_O, MEM_EN_O, MEM_WE_O;
    logic [15:0] TR_DATA_O, HOST_DATA_O, MEM_WDATA_O, MEM_RDATA_I;
    logic [2:0]  EVENT_ADDR_O, MEM_ADDR_O;
    logic [15:0] mem [0:7];

    int checks   = 0;
    int failures = 0;

    trace_mem_ctrl #(.DATA_W(16), .DEPTH(8)) dut (
        .FPGA_CLK_I    (clk),
        .RST_I         (RST_I),
        .EN_I          (EN_I),
        .MODE_I        (MODE_I),
        .TRIG_DELAY_I  (TRIG_DELAY_I),
        .STORE_I       (STORE_I),
        .TR_DATA_I     (TR_DATA_I),
        .REQ_I         (REQ_I),
        .LOAD_O        (LOAD_O),
        .TR_DATA_O     (TR_DATA_O),
        .TRG_EVENT_I   (TRG_EVENT_I),
        .TRG_DELAYED_O (TRG_DELAYED_O),
        .EVENT_ADDR_O  (EVENT_ADDR_O),
        .HOST_REQ_I    (HOST_REQ_I),
        .HOST_WE_I     (HOST_WE_I),
        .HOST_ADDR_I   (HOST_ADDR_I),
        .HOST_DATA_I   (HOST_DATA_I),
        .HOST_DATA_O   (HOST_DATA_O),
        .HOST_ACK_O    (HOST_ACK_O),
        .MEM_EN_O      (MEM_EN_O),
        .MEM_WE_O      (MEM_WE_O),
        .MEM_ADDR_O    (MEM_ADDR_O),
        .MEM_WDATA_O   (MEM_WDATA_O),
        .MEM_RDATA_I   (MEM_RDATA_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MEM_EN_O) begin
            if (MEM_WE_O)
                mem[MEM_ADDR_O] <= MEM_WDATA_O;
            else
                MEM_RDATA_I <= mem[MEM_ADDR_O];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic store_pulse(input string tag, input logic [15:0] d, input int a);
        @(negedge clk);
        STORE_I   = 1'b1;
        TR_DATA_I = d;
        #1;
        check({tag, "_we"}, MEM_WE_O, 1);
        check({tag, "_addr"}, MEM_ADDR_O, a);
        check({tag, "_wdata"}, MEM_WDATA_O, d);
        @(negedge clk);
        STORE_I = 1'b0;
        repeat (2) @(negedge clk);
        #1 check({tag, "_noload"}, LOAD_O, 0);
    endtask

    initial begin
        RST_I = 1'b1; EN_I = 1'b0; MODE_I = 1'b0; STORE_I = 1'b0; REQ_I = 1'b0;
        TRG_EVENT_I = 1'b0; HOST_REQ_I = 1'b0; HOST_WE_I = 1'b0;
        TRIG_DELAY_I = 3'd0; HOST_ADDR_I = 3'd0; TR_DATA_I = '0; HOST_DATA_I = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_mem_en", MEM_EN_O, 0);
        check("rst_load", LOAD_O, 0);
        check("rst_trg", TRG_DELAYED_O, 0);
        check("rst_evaddr", EVENT_ADDR_O, 0);

        // Trace mode, a store every 4th cycle, wrapping the 8-word buffer
        @(negedge clk);
        RST_I = 1'b0;
        EN_I  = 1'b1;
        for (int i = 0; i < 10; i++)
            store_pulse("t1", 16'(16'h0100 + i), i % 8);
        check("t1_err", dut.u_arb.err_ovr, 0);
        check("t1_mem0", mem[0], 16'h0108);
        check("t1_mem1", mem[1], 16'h0109);
        check("t1_mem2", mem[2], 16'h0102);

        // Trigger after 5 stores with delay 3 -> 4 more writes, then frozen
        @(negedge clk);
        EN_I = 1'b0;
        @(negedge clk);
        EN_I = 1'b1;
        TRIG_DELAY_I = 3'd3;
        for (int k = 0; k < 5; k++)
            store_pulse("t2pre", 16'(16'h0200 + k), k);
        @(negedge clk);
        TRG_EVENT_I = 1'b1;
        #1 check("t2_trig_noen", MEM_EN_O, 0);
        @(negedge clk);
        #1 check("t2_evaddr", EVENT_ADDR_O, 5);
        for (int j = 0; j < 4; j++) begin
            store_pulse("t2post", 16'(16'h0300 + j), (5 + j) % 8);
            if (j == 2)
                check("t2_not_yet", TRG_DELAYED_O, 0);
        end
        check("t2_delayed", TRG_DELAYED_O, 1);
        check("t2_frozen", 32'(dut.state), 32'(ST_FROZEN));
        @(negedge clk);
        STORE_I = 1'b1;
        #1 check("t2_frz_st_en", MEM_EN_O, 0);
        @(negedge clk);
        STORE_I = 1'b0;
        #1 check("t2_frz_st_drop", MEM_EN_O, 0);

        // Frozen trace-mode read returns the oldest word at wr_ptr = 1
        @(negedge clk);
        REQ_I = 1'b1;
        #1 check("t2_frz_rd_addr", MEM_ADDR_O, 1);
        @(negedge clk);
        REQ_I = 1'b0;
        #1;
        check("t2_frz_load", LOAD_O, 1);
        check("t2_frz_data", TR_DATA_O, 16'h0201);

        // Reset while frozen with a read in flight
        @(negedge clk);
        REQ_I = 1'b1;
        #1 check("t6_rd_gnt", MEM_EN_O, 1);
        @(negedge clk);
        REQ_I = 1'b0; RST_I = 1'b1; EN_I = 1'b0; TRG_EVENT_I = 1'b0;
        #1 check("t6_inflight", LOAD_O, 1);
        @(negedge clk);
        #1;
        check("t6_load", LOAD_O, 0);
        check("t6_trdata", TR_DATA_O, 0);
        check("t6_trg", TRG_DELAYED_O, 0);
        check("t6_evaddr", EVENT_ADDR_O, 0);
        check("t6_ack", HOST_ACK_O, 0);
        check("t6_hdata", HOST_DATA_O, 0);
        check("t6_mem_en", MEM_EN_O, 0);
        check("t6_state", 32'(dut.state), 32'(ST_IDLE));

        // Simultaneous store, read and host read
        @(negedge clk);
        RST_I = 1'b0;
        EN_I  = 1'b1;
        @(negedge clk);
        STORE_I = 1'b1; TR_DATA_I = 16'h0555; REQ_I = 1'b1;
        HOST_REQ_I = 1'b1; HOST_WE_I = 1'b0; HOST_ADDR_I = 3'd3;
        #1;
        check("t3_c0_we", MEM_WE_O, 1);
        check("t3_c0_addr", MEM_ADDR_O, 0);
        @(negedge clk);
        STORE_I = 1'b0; REQ_I = 1'b0;
        #1;
        check("t3_c1_rd", {MEM_EN_O, MEM_WE_O}, 2'b10);
        check("t3_c1_addr", MEM_ADDR_O, 1);
        check("t3_c1_load", LOAD_O, 0);
        @(negedge clk);
        #1;
        check("t3_c2_host", {MEM_EN_O, MEM_WE_O}, 2'b10);
        check("t3_c2_addr", MEM_ADDR_O, 3);
        check("t3_c2_load", LOAD_O, 1);
        check("t3_c2_data", TR_DATA_O, 16'h0201);
        check("t3_c2_ack", HOST_ACK_O, 0);
        @(negedge clk);
        #1;
        check("t3_c3_ack", HOST_ACK_O, 1);
        check("t3_c3_hdata", HOST_DATA_O, 16'h0203);
        check("t3_c3_no_regrant", MEM_EN_O, 0);
        @(negedge clk);
        HOST_REQ_I = 1'b0;
        #1;
        check("t3_c4_ack", HOST_ACK_O, 0);
        check("t3_c4_hold", TR_DATA_O, 16'h0201);
        check("t3_c4_hhold", HOST_DATA_O, 16'h0203);

        // Store overrun while idle: second pulse dropped, one write on enable
        @(negedge clk);
        EN_I = 1'b0;
        @(negedge clk);
        STORE_I = 1'b1; TR_DATA_I = 16'h0AAA;
        #1 check("t5_idle_st1", MEM_EN_O, 0);
        @(negedge clk);
        TR_DATA_I = 16'h0BBB;
        #1 check("t5_idle_st2", MEM_EN_O, 0);
        @(negedge clk);
        STORE_I = 1'b0;
        EN_I    = 1'b1;
        #1 check("t5_err", dut.u_arb.err_ovr, 1);
        @(negedge clk);
        #1;
        check("t5_we", MEM_WE_O, 1);
        check("t5_addr", MEM_ADDR_O, 0);
        check("t5_wdata", MEM_WDATA_O, 16'h0AAA);
        @(negedge clk);
        #1 check("t5_single", MEM_EN_O, 0);

        // Stream mode: host fills 0..3 while disabled, Tracer reads them back
        @(negedge clk);
        EN_I   = 1'b0;
        MODE_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            HOST_REQ_I = 1'b1; HOST_WE_I = 1'b1;
            HOST_ADDR_I = 3'(k); HOST_DATA_I = 16'(16'h00A0 + k);
            #1;
            check("t4_hwe", MEM_WE_O, 1);
            check("t4_haddr", MEM_ADDR_O, k);
            @(negedge clk);
            HOST_REQ_I = 1'b0;
            #1 check("t4_hack", HOST_ACK_O, 1);
        end
        @(negedge clk);
        HOST_WE_I = 1'b0;
        EN_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            REQ_I = 1'b1;
            #1 check("t4_rd_addr", MEM_ADDR_O, k);
            @(negedge clk);
            REQ_I = 1'b0;
            #1;
            check("t4_load", LOAD_O, 1);
            check("t4_data", TR_DATA_O, 16'h00A0 + k);
        end
        check("t4_rd_ptr", dut.rd_ptr, 4);

        // Trigger is ignored in stream mode
        TRIG_DELAY_I = 3'd0;
        store_pulse("t4s0", 16'h0777, 0);
        TRG_EVENT_I = 1'b1;
        store_pulse("t4s1", 16'h0778, 1);
        check("t4_evaddr", EVENT_ADDR_O, 0);
        check("t4_trg", TRG_DELAYED_O, 0);
        check("t4_state", 32'(dut.state), 32'(ST_RUN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
